// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported synchronous data memory.
// Port 0 is the CPU datapath and port 1 is the loader/debug port.
module dmem_arbiter #(
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          stall0,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [AW:0] LIM = DEPTH[AW:0];

  state_t        state;
  state_t        state_nx;
  logic          last_owner;
  logic          owner;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_err;
  logic          arb;
  logic          win;
  logic          in_acc;
  logic          in_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
    end else begin
      state <= state_nx;
      if (arb) begin
        owner      <= win;
        last_owner <= win;
        l_we       <= win ? we1    : we0;
        l_addr     <= win ? addr1  : addr0;
        l_wdata    <= win ? wdata1 : wdata0;
      end
    end
  end

  // With both ports requesting, the port that did not win last time goes.
  always_comb begin
    arb      = 1'b0;
    win      = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE, RESP: begin
        if (req0 || req1) begin
          arb      = 1'b1;
          win      = req1 & (~req0 | ~last_owner);
          state_nx = ACCESS;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS:  state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  assign l_err   = {1'b0, l_addr} >= LIM;
  assign in_acc  = ~rst & (state == ACCESS);
  assign in_resp = ~rst & (state == RESP);

  assign gnt0   = in_acc & ~owner;
  assign gnt1   = in_acc & owner;
  assign done0  = in_resp & ~owner;
  assign done1  = in_resp & owner;
  assign err    = in_resp & l_err;
  assign stall0 = req0 & ~gnt0;

  // Out-of-range accesses never reach the memory.
  assign mem_en    = in_acc & ~l_err;
  assign mem_we    = in_acc & l_we & ~l_err;
  assign mem_addr  = l_addr;
  assign mem_wdata = l_wdata;
  assign rdata     = (in_resp & ~l_we & ~l_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous memory.
// DEPTH is set to 512 so addresses 512..1023 exercise the error path.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, err, stall0;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .stall0(stall0),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[5] = 32'hDEADBEEF;
    mem[3] = 32'hAAAA5555;
    rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    nxt();
    nxt();
    req0 = 1'b1;
    #1;
    chk("rst_stall0", stall0, 1);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_done", done0 | done1, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    req0 = 1'b0;
    #1;
    chk("rst_stall0_lo", stall0, 0);
    nxt();
    rst = 1'b0;

    // single read
    req0 = 1; we0 = 0; addr0 = 5;
    #1;
    chk("rd_c0_gnt0", gnt0, 0);
    chk("rd_c0_stall0", stall0, 1);
    nxt();
    chk("rd_c1_gnt0", gnt0, 1);
    chk("rd_c1_mem_en", mem_en, 1);
    chk("rd_c1_mem_we", mem_we, 0);
    chk("rd_c1_mem_addr", mem_addr, 5);
    chk("rd_c1_stall0", stall0, 0);
    req0 = 0;
    nxt();
    chk("rd_c2_done0", done0, 1);
    chk("rd_c2_rdata", rdata, 32'hDEADBEEF);
    chk("rd_c2_err", err, 0);
    nxt();
    chk("rd_c3_done0", done0, 0);

    // contention straight after reset
    rst = 1;
    nxt();
    rst = 0;
    req0 = 1; we0 = 0; addr0 = 5;
    req1 = 1; we1 = 0; addr1 = 3;
    nxt();
    chk("ct_c1_gnt0", gnt0, 1);
    chk("ct_c1_gnt1", gnt1, 0);
    req0 = 0;
    nxt();
    chk("ct_c2_done0", done0, 1);
    chk("ct_c2_rdata", rdata, 32'hDEADBEEF);
    chk("ct_c2_gnt1", gnt1, 0);
    nxt();
    chk("ct_c3_gnt1", gnt1, 1);
    chk("ct_c3_done0", done0, 0);
    req1 = 0;
    nxt();
    chk("ct_c4_done1", done1, 1);
    chk("ct_c4_done0", done0, 0);
    chk("ct_c4_rdata", rdata, 32'hAAAA5555);
    nxt();

    // round robin with both ports held high
    req0 = 1; req1 = 1; addr0 = 5; addr1 = 3;
    for (int i = 0; i < 6; i++) begin
      nxt();
      chk($sformatf("rr%0d_gnt0", i), gnt0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_gnt1", i), gnt1, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("rr%0d_stall0", i), stall0, (i % 2 == 1) ? 1 : 0);
      if (i == 5) begin
        req0 = 0; req1 = 0;
      end
      nxt();
      chk($sformatf("rr%0d_done0", i), done0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_done1", i), done1, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("rr%0d_rdata", i), rdata,
          (i % 2 == 0) ? 32'hDEADBEEF : 32'hAAAA5555);
      if (i < 5) chk($sformatf("rr%0d_resp_stall0", i), stall0, 1);
    end
    nxt();
    chk("rr_idle_gnt", gnt0 | gnt1, 0);

    // in-range write from port 1
    req1 = 1; we1 = 1; addr1 = 7; wdata1 = 32'h77;
    nxt();
    chk("wr_c1_gnt1", gnt1, 1);
    chk("wr_c1_mem_we", mem_we, 1);
    chk("wr_c1_mem_wdata", mem_wdata, 32'h77);
    req1 = 0;
    nxt();
    chk("wr_c2_done1", done1, 1);
    chk("wr_c2_rdata", rdata, 0);
    chk("wr_mem7", mem[7], 32'h77);
    nxt();

    // out-of-range write
    req1 = 1; we1 = 1; addr1 = 600; wdata1 = 32'h5;
    nxt();
    chk("oor_c1_gnt1", gnt1, 1);
    chk("oor_c1_mem_en", mem_en, 0);
    chk("oor_c1_mem_we", mem_we, 0);
    req1 = 0;
    nxt();
    chk("oor_c2_done1", done1, 1);
    chk("oor_c2_err", err, 1);
    chk("oor_c2_rdata", rdata, 0);
    chk("oor_mem600", mem[600], 0);
    nxt();
    chk("oor_c3_err", err, 0);

    // reset during the ACCESS cycle of a write
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 32'h1234;
    nxt();
    chk("rm_c1_gnt0", gnt0, 1);
    rst = 1;
    req0 = 0;
    #1;
    chk("rm_mem_we", mem_we, 0);
    chk("rm_mem_en", mem_en, 0);
    chk("rm_gnt0", gnt0, 0);
    nxt();
    rst = 0;
    #1;
    chk("rm_done0", done0, 0);
    chk("rm_mem3", mem[3], 32'hAAAA5555);
    nxt();
    chk("rm_post_done0", done0, 0);

    // idle after reset: read back addr 3 with isolated latency
    req0 = 1; we0 = 0; addr0 = 3;
    nxt();
    chk("rb_c1_gnt0", gnt0, 1);
    req0 = 0;
    nxt();
    chk("rb_c2_done0", done0, 1);
    chk("rb_c2_rdata", rdata, 32'hAAAA5555);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
